ctrl_rst_seq: RTL

- Reset sequencer driven by the system reset generator output.
- Takes the single stretched system reset and releases the downstream reset domains in order:
  - memory controller first;
  - then the chipset/system logic once memory init completes;
  - then the CPU.
- Also services a register-requested soft reset, which re-sequences system and CPU without touching memory.
- Sits between the reset generator and the subsystem reset inputs.

---
 rtl/ctrl_rst_seq_pkg.sv | 24 ++
 rtl/ctrl_rst_seq_if.sv | 36 +++
 rtl/ctrl_rst_seq_sync2.sv | 31 +++
 rtl/ctrl_rst_seq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ctrl_rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, counter width and
// synchronizer depth, plus the delay-to-load-value helper.
package ctrl_rst_seq_pkg;

  localparam int CNT_W      = 16;
  localparam int SYNC_DEPTH = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MEM  = 3'd1,
    ST_SYSD = 3'd2,
    ST_CPUD = 3'd3,
    ST_RUN  = 3'd4,
    ST_SOFT = 3'd5
  } state_e;

  // A state lasting N cycles loads N-1 and exits on the cycle the counter reads 0.
  function automatic cnt_t load_val(input int cycles);
    return cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/ctrl_rst_seq_if.sv
// Signal bundle between the reset sequencer (master) and the subsystems it controls.
// Optional status signals exist only with CTRL_RST_SEQ_STATUS_EN defined.
interface ctrl_rst_seq_if;

  // All signals are plain levels, no valid/ready: mem_rdy may change at any time
  // (it is synchronized inside), soft_req acts on its rising edge only, and every
  // output is a registered level that holds until the sequencer changes state.
  logic mem_rdy;
  logic soft_req;
  logic rst_mem;
  logic rst_sys;
  logic rst_cpu;
  logic seq_done;
  logic mem_to_err;
`ifdef CTRL_RST_SEQ_STATUS_EN
  logic [2:0] seq_state;
  logic [7:0] soft_cnt;
`endif

  modport master (
    input  mem_rdy, soft_req,
    output rst_mem, rst_sys, rst_cpu, seq_done, mem_to_err
`ifdef CTRL_RST_SEQ_STATUS_EN
    , output seq_state, soft_cnt
`endif
  );

  modport slave (
    output mem_rdy, soft_req,
    input  rst_mem, rst_sys, rst_cpu, seq_done, mem_to_err
`ifdef CTRL_RST_SEQ_STATUS_EN
    , input seq_state, soft_cnt
`endif
  );

endinterface

// File: rtl/ctrl_rst_seq_sync2.sv
// ctrl_sync2: generic multi-bit flop chain synchronizer (depth from the package),
// cleared by the synchronous active-high reset.
module ctrl_sync2
  import ctrl_rst_seq_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [SYNC_DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [SYNC_DEPTH-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[SYNC_DEPTH-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[SYNC_DEPTH-1];

endmodule

// File: rtl/ctrl_rst_seq.sv
// ctrl_rst_seq: releases memory, then system, then CPU resets in order and replays
// system/CPU on a soft request. Defining CTRL_RST_SEQ_STATUS_EN adds seq_state/soft_cnt.
module ctrl_rst_seq
  import ctrl_rst_seq_pkg::*;
#(
  parameter int SYS_DLY  = 16,
  parameter int CPU_DLY  = 16,
  parameter int SOFT_LEN = 32,
  parameter int MEM_TO   = 65535
) (
  input logic            clk,
  input logic            rst,
  ctrl_rst_seq_if.master bus
);

  localparam cnt_t SYS_LD  = load_val(SYS_DLY);
  localparam cnt_t CPU_LD  = load_val(CPU_DLY);
  localparam cnt_t SOFT_LD = load_val(SOFT_LEN);
  localparam cnt_t MEM_LD  = load_val(MEM_TO);

  logic   mrdy_s;
  logic   req_pulse;
  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   req_prev_q, req_prev_d;
  logic   mrdy_ref_q, mrdy_ref_d;
  logic   rst_mem_q, rst_mem_d;
  logic   rst_sys_q, rst_sys_d;
  logic   rst_cpu_q, rst_cpu_d;
  logic   seq_done_q, seq_done_d;
  logic   mem_to_err_q, mem_to_err_d;

  ctrl_sync2 #(.WIDTH(1)) u_mrdy_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.mem_rdy),
    .dout (mrdy_s)
  );

  assign req_pulse = bus.soft_req & ~req_prev_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q != '0) ? cnt_q - cnt_t'(1) : '0;
    req_prev_d   = bus.soft_req;
    mrdy_ref_d   = mrdy_ref_q;
    mem_to_err_d = mem_to_err_q;

    // mrdy_ref holds the last memory-ready level seen in MEM or RUN; it is frozen
    // through SOFT/SYSD/CPUD so a loss during a soft reset is caught back in RUN.
    case (state_q)
      ST_IDLE: begin
        state_d    = ST_MEM;
        cnt_d      = MEM_LD;
        mrdy_ref_d = 1'b0;
      end
      ST_MEM: begin
        mrdy_ref_d = mrdy_s;
        if (mrdy_s) begin
          state_d = ST_SYSD;
          cnt_d   = SYS_LD;
        end else if (cnt_q == '0) begin
          mem_to_err_d = 1'b1;
          state_d      = ST_SYSD;
          cnt_d        = SYS_LD;
        end
      end
      ST_SYSD: begin
        if (cnt_q == '0) begin
          state_d = ST_CPUD;
          cnt_d   = CPU_LD;
        end
      end
      ST_CPUD: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (req_pulse) begin
          state_d = ST_SOFT;
          cnt_d   = SOFT_LD;
        end else begin
          mrdy_ref_d = mrdy_s;
          if (mrdy_ref_q && !mrdy_s) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_SOFT: begin
        if (cnt_q == '0) begin
          state_d = ST_SYSD;
          cnt_d   = SYS_LD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Moore outputs decoded from the next state so they move with the state register.
    rst_mem_d  = (state_d == ST_IDLE);
    rst_sys_d  = (state_d == ST_IDLE) || (state_d == ST_MEM) ||
                 (state_d == ST_SYSD) || (state_d == ST_SOFT);
    rst_cpu_d  = (state_d != ST_RUN);
    seq_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_prev_q   <= 1'b0;
      mrdy_ref_q   <= 1'b0;
      rst_mem_q    <= 1'b1;
      rst_sys_q    <= 1'b1;
      rst_cpu_q    <= 1'b1;
      seq_done_q   <= 1'b0;
      mem_to_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_prev_q   <= req_prev_d;
      mrdy_ref_q   <= mrdy_ref_d;
      rst_mem_q    <= rst_mem_d;
      rst_sys_q    <= rst_sys_d;
      rst_cpu_q    <= rst_cpu_d;
      seq_done_q   <= seq_done_d;
      mem_to_err_q <= mem_to_err_d;
    end
  end

  assign bus.rst_mem    = rst_mem_q;
  assign bus.rst_sys    = rst_sys_q;
  assign bus.rst_cpu    = rst_cpu_q;
  assign bus.seq_done   = seq_done_q;
  assign bus.mem_to_err = mem_to_err_q;

`ifdef CTRL_RST_SEQ_STATUS_EN
  logic [7:0] soft_cnt_q, soft_cnt_d;

  always_comb begin
    soft_cnt_d = soft_cnt_q;
    if (state_q == ST_SOFT && cnt_q == '0 && soft_cnt_q != 8'hFF) begin
      soft_cnt_d = soft_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      soft_cnt_q <= '0;
    end else begin
      soft_cnt_q <= soft_cnt_d;
    end
  end

  assign bus.seq_state = state_q;
  assign bus.soft_cnt  = soft_cnt_q;
`endif

  // Zero-length delays would wrap the 16-bit load value.
  param_nonzero_a: assert property (@(posedge clk)
    (SYS_DLY > 0) && (CPU_DLY > 0) && (SOFT_LEN > 0) && (MEM_TO > 0));

endmodule
